// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detect fields in, per-stage enables and flushes out
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_jump;
  logic pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush;
  modport master (
    output id_rs, id_rt, ex_rd, id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_jump,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush
  );
  modport slave (
    input  id_rs, id_rt, ex_rd, id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_jump,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall and branch/jump flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 enable,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     redirect_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;
  // control word order: pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush
  localparam logic [5:0] CTL_RUN = 6'b111000, CTL_STALL = 6'b001010, CTL_REDIR = 6'b111111;
  state_t st, nxt;
  logic [3:0] bub, nbub;
  logic [5:0] ctl;
  logic inc_s, inc_r, hazard, redirect;
  assign hazard = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                  (bus.ex_rd == bus.id_rs || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
  assign redirect = (bus.mem_branch && bus.mem_zero) || bus.mem_jump;
  assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush} = ctl;
  assign state = st;
  always_comb begin
    nxt = st;
    nbub = bub;
    ctl = 6'b0;
    inc_s = 1'b0;
    inc_r = 1'b0;
    case (st)
      IDLE: nxt = enable ? RUN : IDLE;
      RUN: if (enable) begin
        ctl = redirect ? CTL_REDIR : hazard ? CTL_STALL : CTL_RUN;
        inc_r = redirect;
        inc_s = !redirect && hazard;
        if (inc_s && LOAD_LAT > 1) begin
          nxt = STALL;
          nbub = 4'(LOAD_LAT - 1);
        end
      end
      STALL: if (enable) begin
        // a redirect squashes the stalled ID instruction, so the stall is abandoned
        ctl = redirect ? CTL_REDIR : CTL_STALL;
        inc_r = redirect;
        inc_s = !redirect;
        nbub = redirect ? 4'd0 : bub - 4'd1;
        nxt = (redirect || bub == 4'd1) ? RUN : STALL;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      st <= IDLE;
      bub <= 4'd0;
      stall_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      st <= nxt;
      bub <= nbub;
      if (inc_s && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (inc_r && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: three parameterisations driven in lockstep, scoreboarded against a behavioural model
module tb_pipeline_hazard_ctrl;
  typedef logic [2:0][39:0] exp_t;
  logic clk = 1'b0, arst = 1'b1, en = 1'b0;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic ut = 0, mr = 0, br = 0, z = 0, j = 0;
  logic [19:0] in_vec;
  logic [1:0] st0, st1, st2;
  logic [15:0] sc0, rc0, sc1, rc1;
  logic [1:0] sc2, rc2;
  logic [39:0] act [3];
  exp_t q [$];
  int tests = 0, fails = 0;
  int live [3], left [3], scnt [3], rcnt [3];
  int lat [3] = '{1, 3, 3};
  int mx [3] = '{65535, 65535, 3};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if bus0 ();
  pipeline_hazard_ctrl_if bus1 ();
  pipeline_hazard_ctrl_if bus2 ();
  assign in_vec = {rs, rt, rd, ut, mr, br, z, j};
  assign {bus0.id_rs, bus0.id_rt, bus0.ex_rd, bus0.id_uses_rt, bus0.ex_mem_read, bus0.mem_branch, bus0.mem_zero, bus0.mem_jump} = in_vec;
  assign {bus1.id_rs, bus1.id_rt, bus1.ex_rd, bus1.id_uses_rt, bus1.ex_mem_read, bus1.mem_branch, bus1.mem_zero, bus1.mem_jump} = in_vec;
  assign {bus2.id_rs, bus2.id_rt, bus2.ex_rd, bus2.id_uses_rt, bus2.ex_mem_read, bus2.mem_branch, bus2.mem_zero, bus2.mem_jump} = in_vec;
  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut0 (.clk(clk), .arst(arst), .enable(en), .bus(bus0), .state(st0), .stall_cnt(sc0), .redirect_cnt(rc0));
  pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut1 (.clk(clk), .arst(arst), .enable(en), .bus(bus1), .state(st1), .stall_cnt(sc1), .redirect_cnt(rc1));
  pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(2)) dut2 (.clk(clk), .arst(arst), .enable(en), .bus(bus2), .state(st2), .stall_cnt(sc2), .redirect_cnt(rc2));
  assign act[0] = {bus0.pc_en, bus0.if_id_en, bus0.id_ex_en, bus0.if_id_flush, bus0.id_ex_flush, bus0.ex_mem_flush, st0, sc0, rc0};
  assign act[1] = {bus1.pc_en, bus1.if_id_en, bus1.id_ex_en, bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_flush, st1, sc1, rc1};
  assign act[2] = {bus2.pc_en, bus2.if_id_en, bus2.id_ex_en, bus2.if_id_flush, bus2.id_ex_flush, bus2.ex_mem_flush, st2, 14'd0, sc2, 14'd0, rc2};
  // Reference: a pipeline is either idle or live; a live pipeline owes 'left' further bubbles.
  task automatic model_step(output exp_t e);
    bit hz, rdr;
    logic [5:0] c;
    logic [1:0] s;
    int sc_now, rc_now;
    hz = mr && rd != 0 && (rd == rs || (ut && rd == rt));
    rdr = (br && z) || j;
    for (int d = 0; d < 3; d++) begin
      c = 6'b0;
      s = live[d] == 0 ? 2'd0 : left[d] > 0 ? 2'd2 : 2'd1;
      sc_now = scnt[d];
      rc_now = rcnt[d];
      if (en) begin
        if (live[d] == 0) live[d] = 1;
        else if (rdr) begin
          c = 6'b111111;
          rcnt[d] = rcnt[d] < mx[d] ? rcnt[d] + 1 : rcnt[d];
          left[d] = 0;
        end else if (left[d] > 0 || hz) begin
          c = 6'b001010;
          scnt[d] = scnt[d] < mx[d] ? scnt[d] + 1 : scnt[d];
          left[d] = left[d] > 0 ? left[d] - 1 : lat[d] - 1;
        end else c = 6'b111000;
      end
      e[d] = {c, s, 16'(sc_now), 16'(rc_now)};
    end
  endtask
  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    arst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      live[d] = 0; left[d] = 0; scnt[d] = 0; rcnt[d] = 0;
      e[d] = 40'd0;
    end
    q.push_back(e);
  endtask
  task automatic cyc(input bit e_in, input logic [4:0] rs_in, rt_in, input bit ut_in, mr_in,
                     input logic [4:0] rd_in, input bit br_in, z_in, j_in, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      arst = 1'b0;
      en = e_in; rs = rs_in; rt = rt_in; ut = ut_in; mr = mr_in; rd = rd_in; br = br_in; z = z_in; j = j_in;
      model_step(e);
      q.push_back(e);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int d = 0; d < 3; d++) begin
          tests++;
          if (act[d] !== e[d]) begin
            fails++;
            $display("FAIL dut%0d t=%0t ctl/state/stall/redir got %b/%0d/%0d/%0d exp %b/%0d/%0d/%0d",
                     d, $time, act[d][39:34], act[d][33:32], act[d][31:16], act[d][15:0],
                     e[d][39:34], e[d][33:32], e[d][31:16], e[d][15:0]);
          end
        end
      end
    end
  end
  initial begin : stimulus
    reset_pulse();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    cyc(1, 5, 0, 0, 1, 5, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    cyc(1, 0, 7, 0, 1, 7, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    cyc(1, 0, 7, 1, 1, 7, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    cyc(1, 5, 0, 0, 1, 5, 1, 1, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    cyc(1, 5, 0, 0, 1, 5, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    cyc(1, 5, 0, 0, 1, 5, 0, 0, 0, 1); cyc(0, 5, 0, 0, 1, 5, 0, 0, 0, 4); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    cyc(1, 5, 0, 0, 1, 5, 0, 0, 0, 1); reset_pulse(); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3, 0, 0, 1, 3, 0, 0, 0, 1); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    end
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else cyc($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 15) == 0, 1);
    end
    @(negedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards between the ID and EX stages and inserts bubbles. It squashes wrong-path instructions when a branch or jump resolves in MEM. It drives the per-stage pipeline-register enables and flushes, replacing the single global enable, and keeps saturating performance counters for stalls and redirects.

Parameters:
LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (1..15; >1 reserves room for a slower data memory)
CNT_W, 16, width of the stall and redirect performance counters

Ports:
clk  in  1  clock, all state on rising edge
arst  in  1  asynchronous reset, active-high
enable  in  1  global run enable; low freezes the pipeline
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
mem_branch  in  1  branch instruction in MEM
mem_zero  in  1  registered ALU zero flag for the MEM instruction
mem_jump  in  1  jump instruction in MEM
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX, EX/MEM, MEM/WB register enable
if_id_flush  out  1  load NOP into IF/ID on this edge
id_ex_flush  out  1  load zero control bits into ID/EX on this edge
ex_mem_flush  out  1  load zero control bits into EX/MEM on this edge
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 STALL
stall_cnt  out  CNT_W  total bubble cycles inserted, saturating
redirect_cnt  out  CNT_W  total taken branches and jumps, saturating

Behaviour:
- Reset (arst high, async): state=IDLE, internal bubble counter=0, stall_cnt=0, redirect_cnt=0. All enables and flushes are 0 while state=IDLE.
- Derived terms:
  - hazard = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
  - redirect = (mem_branch & mem_zero) | mem_jump.
- enable=0 in any state: all outputs 0; FSM, bubble counter and perf counters hold.
- IDLE: goes to RUN on the first cycle with enable=1. Outputs stay 0 during that cycle.
- RUN, enable=1, priority redirect > hazard > normal:
  - redirect: pc_en=1 (PC loads target), if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. redirect_cnt+1. Stays in RUN. A hazard in the same cycle is ignored because the ID instruction is squashed.
  - hazard: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, other flushes 0. stall_cnt+1.
    - LOAD_LAT=1: stays in RUN.
    - LOAD_LAT>1: goes to STALL with bubble counter=LOAD_LAT-1.
  - otherwise: pc_en=if_id_en=id_ex_en=1, all flushes 0.
- STALL, enable=1:
  - Same outputs as the RUN hazard case. Does not recompare registers. stall_cnt+1. Bubble counter-1.
  - Goes to RUN on the cycle the counter reaches 1, i.e. exactly LOAD_LAT bubbles in total.
  - redirect in STALL: takes the RUN redirect outputs, aborts the stall, next state RUN, counter cleared. That cycle does not count as a stall.
- Flush outputs are combinational from state and inputs, so they take effect on the same edge as detection (0-cycle latency). Only state and counters are registered.
- Counters stick at 2^CNT_W-1.
- Register $0 never causes a hazard.
- arst mid-STALL: returns to IDLE immediately; the partial stall is discarded.
- Unused state encoding 3 recovers to IDLE on the next clock.

Test Plan:
1. Reset, then enable=1 and no hazards for 10 cycles -> state 0 then 1; pc_en=if_id_en=id_ex_en=1 from cycle 2; all flushes 0; counters 0.
2. ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle, LOAD_LAT=1 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
3. ex_rd=7, id_rt=7 with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall. LOAD_LAT=3 -> three consecutive bubble cycles, state=2 for two of them, stall_cnt=3.
4. mem_branch=1, mem_zero=1 together with a hazard -> if_id_flush, id_ex_flush and ex_mem_flush all 1, pc_en=1, redirect_cnt=1, stall_cnt unchanged. mem_branch=1 with mem_zero=0 -> no flush.
5. LOAD_LAT=3: hazard, then mem_jump=1 on the second bubble cycle -> redirect outputs that cycle, state=1 next cycle, stall_cnt=1.
6. enable=0 mid-STALL for 4 cycles -> all outputs 0, state holds at 2; on re-enable the remaining bubbles complete. arst pulse mid-STALL -> state 0 and counters 0 asynchronously. CNT_W=2 with 5 stalls -> stall_cnt=3.
